// File: rtl/mash_ncl_if.sv
// mash_ncl_if: sample-strobe / carry / combined-output bundle of the MASH 1-1-1
// noise-cancellation combiner.
//   en       sample strobe (carries consumed only when high)
//   c1..c3   1-bit carries of the three cascaded accumulators
//   y_out    signed combined output, two's complement, OUT_W bits
//   y_uns    y_out + OFFSET, unsigned
//   y_valid  one-cycle qualifier for a fully-formed sample
// master drives strobe and carries; slave (the combiner) drives the outputs.
interface mash_ncl_if #(
  parameter int OUT_W = 4
);
  logic                    en;
  logic                    c1;
  logic                    c2;
  logic                    c3;
  logic signed [OUT_W-1:0] y_out;
  logic        [OUT_W-1:0] y_uns;
  logic                    y_valid;

  modport master (
    output en, c1, c2, c3,
    input  y_out, y_uns, y_valid
  );

  modport slave (
    input  en, c1, c2, c3,
    output y_out, y_uns, y_valid
  );
endinterface

// File: rtl/mash_ncl.sv
// mash_ncl: noise-cancellation combiner for a 3-stage MASH 1-1-1 modulator.
// Forms y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3 from the stage carries, one clock
// after an enabled sample, and presents it signed (y_out) and offset-shifted
// (y_uns) for the divider-modulus adder.
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset, synchronous release upstream
//   bus    mash_ncl_if.slave: en, c1, c2, c3 in; y_out, y_uns, y_valid out
module mash_ncl #(
  parameter int OUT_W  = 4,
  parameter int OFFSET = 3,
  parameter int WARMUP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mash_ncl_if.slave     bus
);

  localparam int CNT_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CNT_W-1:0] WARMUP_V = CNT_W'(WARMUP);
  localparam logic [OUT_W-1:0] OFFSET_V = OUT_W'(OFFSET);

  // Zero-extend a carry bit to the signed output width.
  function automatic logic signed [OUT_W-1:0] widen(input logic b);
    return {{(OUT_W-1){1'b0}}, b};
  endfunction

  logic                    c2_d1_r;
  logic                    c3_d1_r;
  logic                    c3_d2_r;
  logic [CNT_W-1:0]        cnt_r;
  logic signed [OUT_W-1:0] y_out_r;
  logic        [OUT_W-1:0] y_uns_r;
  logic                    y_valid_r;

  logic signed [OUT_W-1:0] sum_s;
  logic        [OUT_W-1:0] uns_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    warm_s;

  // Combined sample; range -3..+4 fits OUT_W>=4 so modular arithmetic is exact.
  always_comb begin
    sum_s = widen(bus.c1)
          + widen(bus.c2) - widen(c2_d1_r)
          + widen(bus.c3) - (widen(c3_d1_r) <<< 1) + widen(c3_d2_r);
    uns_s = $unsigned(sum_s) + OFFSET_V;
  end

  // Saturating warm-up counter; valid judged on the pre-update count.
  always_comb begin
    if (cnt_r < WARMUP_V) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      warm_s    = 1'b0;
    end else begin
      cnt_nxt_s = cnt_r;
      warm_s    = 1'b1;
    end
  end

  // History, output and warm-up state; everything except valid holds when en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2_d1_r   <= 1'b0;
      c3_d1_r   <= 1'b0;
      c3_d2_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      y_out_r   <= {OUT_W{1'b0}};
      y_uns_r   <= OFFSET_V;
      y_valid_r <= 1'b0;
    end else if (bus.en) begin
      c2_d1_r   <= bus.c2;
      c3_d2_r   <= c3_d1_r;
      c3_d1_r   <= bus.c3;
      cnt_r     <= cnt_nxt_s;
      y_out_r   <= sum_s;
      y_uns_r   <= uns_s;
      y_valid_r <= warm_s;
    end else begin
      y_valid_r <= 1'b0;
    end
  end

  assign bus.y_out   = y_out_r;
  assign bus.y_uns   = y_uns_r;
  assign bus.y_valid = y_valid_r;

endmodule

// File: tb/tb_mash_ncl.sv
// tb_mash_ncl: self-checking bench for mash_ncl. A reference model keeps the
// accepted carry history in queues and evaluates the combiner equation with
// integer arithmetic; directed scenarios use constants.
module tb_mash_ncl;
  localparam int OUT_W  = 4;
  localparam int OFFSET = 3;
  localparam int WARMUP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mash_ncl_if #(.OUT_W(OUT_W)) bus ();

  mash_ncl #(.OUT_W(OUT_W), .OFFSET(OFFSET), .WARMUP(WARMUP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int h2[$];
  int h3[$];
  int nsamp;
  int exp_y;
  int exp_uns;
  logic exp_v;

  function automatic int back(input int q[$], input int k);
    if (q.size() >= k) return q[q.size() - k];
    return 0;
  endfunction

  task automatic model_reset();
    h2.delete();
    h3.delete();
    nsamp   = 0;
    exp_y   = 0;
    exp_uns = OFFSET;
    exp_v   = 1'b0;
  endtask

  task automatic model_sample(input int a, input int b, input int c);
    int y;
    y = a + (b - back(h2, 1)) + (c - 2 * back(h3, 1) + back(h3, 2));
    exp_v = (nsamp >= WARMUP);
    nsamp++;
    h2.push_back(b);
    h3.push_back(c);
    if (h2.size() > 2) void'(h2.pop_front());
    if (h3.size() > 2) void'(h3.pop_front());
    exp_y   = y;
    exp_uns = y + OFFSET;
  endtask

  task automatic step(input logic e, input logic a, input logic b, input logic c);
    bus.en = e;
    bus.c1 = a;
    bus.c2 = b;
    bus.c3 = c;
    @(posedge clk);
    #1;
    if (e) model_sample(int'(a), int'(b), int'(c));
    else   exp_v = 1'b0;
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int got_y();
    int g;
    g = bus.y_out;
    return g;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.en = 1'b1;
      bus.c1 = 1'($urandom);
      bus.c2 = 1'($urandom);
      bus.c3 = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (got_y() !== 0) begin
        errors++; $display("FAIL reset_y: got %0d expected 0", got_y());
      end
      checks++;
      if (bus.y_uns !== 4'd3) begin
        errors++; $display("FAIL reset_uns: got %0d expected 3", bus.y_uns);
      end
      checks++;
      if (bus.y_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid: got %b expected 0", bus.y_valid);
      end
    end
    bus.en = 1'b0;
    rst_n  = 1'b1;
    model_reset();
  endtask

  task automatic test_constant();
    int ey[6] = '{3, 0, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (got_y() !== ey[i]) begin
        errors++; $display("FAIL const_y[%0d]: got %0d expected %0d", i, got_y(), ey[i]);
      end
      checks++;
      if (bus.y_valid !== (i >= 2)) begin
        errors++; $display("FAIL const_valid[%0d]: got %b expected %b", i, bus.y_valid, (i >= 2));
      end
    end
  endtask

  task automatic test_c3_seq();
    int c3s[4] = '{1, 0, 1, 0};
    int ey[4]  = '{1, -2, 2, -2};
    int eu[4]  = '{4, 1, 5, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'(c3s[i]));
      checks++;
      if (got_y() !== ey[i]) begin
        errors++; $display("FAIL c3seq_y[%0d]: got %0d expected %0d", i, got_y(), ey[i]);
      end
      checks++;
      if (int'(bus.y_uns) !== eu[i]) begin
        errors++; $display("FAIL c3seq_uns[%0d]: got %0d expected %0d", i, bus.y_uns, eu[i]);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);   // history (0,0,1)
    checks++;
    if (bus.y_out !== 4'b0100) begin
      errors++; $display("FAIL ext_max: got %b expected 0100", bus.y_out);
    end
    checks++;
    if (bus.y_valid !== 1'b1) begin
      errors++; $display("FAIL ext_max_valid: got %b expected 1", bus.y_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);   // history (1,1,0)
    checks++;
    if (bus.y_out !== 4'b1101) begin
      errors++; $display("FAIL ext_min: got %b expected 1101", bus.y_out);
    end
    checks++;
    if (bus.y_uns !== 4'd0) begin
      errors++; $display("FAIL ext_min_uns: got %0d expected 0", bus.y_uns);
    end
  endtask

  task automatic test_gaps();
    logic en_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [OUT_W-1:0] held_y;
    logic [OUT_W-1:0] held_u;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        held_y = bus.y_out;
        held_u = bus.y_uns;
        step(en_pat[i], 1'($urandom), 1'($urandom), 1'($urandom));
        if (!en_pat[i]) begin
          checks++;
          if (bus.y_out !== held_y || bus.y_uns !== held_u) begin
            errors++; $display("FAIL gap_hold: got %0d/%0d expected %0d/%0d",
                               bus.y_out, bus.y_uns, held_y, held_u);
          end
        end
        checks++;
        if (got_y() !== exp_y || int'(bus.y_uns) !== exp_uns || bus.y_valid !== exp_v) begin
          errors++; $display("FAIL gap_model: got y=%0d u=%0d v=%b expected y=%0d u=%0d v=%b",
                             got_y(), bus.y_uns, bus.y_valid, exp_y, exp_uns, exp_v);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'($urandom), 1'b1);
    bus.en = 1'b1;
    bus.c1 = 1'b1;
    bus.c2 = 1'b1;
    bus.c3 = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_y() !== 0 || bus.y_uns !== 4'd3 || bus.y_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: got y=%0d u=%0d v=%b expected y=0 u=3 v=0",
                         got_y(), bus.y_uns, bus.y_valid);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        bus.c1 = 1'($urandom);
        bus.c2 = 1'($urandom);
        bus.c3 = 1'($urandom);
      end
      step(1'b1, bus.c1, bus.c2, bus.c3);
      checks++;
      if (bus.y_valid !== (i >= 2)) begin
        errors++; $display("FAIL midrst_valid[%0d]: got %b expected %b", i, bus.y_valid, (i >= 2));
      end
      checks++;
      if (got_y() !== exp_y || int'(bus.y_uns) !== exp_uns) begin
        errors++; $display("FAIL midrst_model[%0d]: got y=%0d u=%0d expected y=%0d u=%0d",
                           i, got_y(), bus.y_uns, exp_y, exp_uns);
      end
    end
  endtask

  task automatic test_random();
    int acc1 = 0, acc2 = 0, acc3 = 0;
    int s1, s2, s3;
    longint sum_y = 0;
    longint n = 0;
    longint dev;
    logic e;
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      e  = (($urandom % 4) != 0);
      s1 = acc1 + 32'h1234;
      s2 = acc2 + (s1 & 32'hFFFF);
      s3 = acc3 + (s2 & 32'hFFFF);
      step(e, 1'(s1 >> 16), 1'(s2 >> 16), 1'(s3 >> 16));
      if (e) begin
        acc1  = s1 & 32'hFFFF;
        acc2  = s2 & 32'hFFFF;
        acc3  = s3 & 32'hFFFF;
        sum_y += got_y();
        n++;
      end
      checks++;
      if (got_y() !== exp_y || int'(bus.y_uns) !== exp_uns || bus.y_valid !== exp_v) begin
        errors++; $display("FAIL rand[%0d]: got y=%0d u=%0d v=%b expected y=%0d u=%0d v=%b",
                           i, got_y(), bus.y_uns, bus.y_valid, exp_y, exp_uns, exp_v);
      end
    end
    dev = sum_y * 65536 - n * 64'sd4660;
    if (dev < 0) dev = -dev;
    checks++;
    if (dev > 5 * 65536) begin
      errors++; $display("FAIL rand_mean: got sum=%0d over %0d samples expected about %0d",
                         sum_y, n, (n * 4660) / 65536);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.c1 = 1'b0;
    bus.c2 = 1'b0;
    bus.c3 = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_constant();
    test_c3_seq();
    test_extremes();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
